pe_param: RTL
=============

Name: pe_param

Overview:
- Parametrised successor to the lab3 row-stationary processing element (PE).
- Holds filter, ifmap-window and psum scratchpads.
- Performs channel-packed 1-D convolution over a sliding ifmap window for up to MAX_P filters.
- Streams p+1 output psums per output column over valid/ready ports.
- Adds over the previous PE: runtime kernel width, signed/unsigned ifmap mode, a done flag, and restart without reset. Sits inside the PE_array, driven by the GLB/NoC.

Parameters:
- DATA_BITS, 32, width of ifmap/filter/ipsum/opsum buses.
- IFMAP_W, 8, ifmap element width.
- FILTER_W, 8, filter element width.
- PSUM_W, 32, psum width (must equal DATA_BITS).
- MAX_CH, 4, channels packed per ifmap/filter word (DATA_BITS/IFMAP_W).
- MAX_S, 4, maximum kernel width.
- MAX_P, 4, maximum filters held.
- CONFIG_SIZE, 12, config word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- PE_en  in  1  start; sampled only in IDLE
- i_config  in  CONFIG_SIZE  [1:0] q = channels-1, [6:2] F = columns-1, [8:7] p = filters-1, [9] mode, [11:10] s = kernel width-1
- ifmap, filter, ipsum  in  DATA_BITS  packed lanes; lane i = bits [i*W +: W]
- ifmap_valid, filter_valid, ipsum_valid  in  1
- opsum_ready  in  1
- ifmap_ready, filter_ready, ipsum_ready  out  1
- opsum  out  DATA_BITS
- opsum_valid  out  1
- done  out  1  run complete

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Transfer rule: a transfer occurs when valid && ready are both high at a clk edge. Ready/valid outputs are a function of state only.
- Reset values: all ready/valid outputs 0, done 0, opsum 0, state IDLE, all counters/indices 0. Scratchpad contents are undefined after reset.
- opsum = ofmap_spad[cnt] while opsum_valid is high, else 0.
- IDLE: on PE_en=1, latch all i_config fields that cycle, go to LOAD_FILTER.
- LOAD_FILTER (filter_ready=1):
  - Accept (p+1)*(s+1) words, word k -> filter_spad[m = k/(s+1)][f = k%(s+1)][0..MAX_CH-1].
  - After the last word, go to LOAD_IFMAP.
- LOAD_IFMAP (ifmap_ready=1): accept s+1 words into window slots 0..s, then go to LOAD_IPSUM.
- SHIFT_IFMAP (ifmap_ready=1): on transfer, slot j <= slot j+1 for j<s, slot s <= new word, then go to LOAD_IPSUM.
- LOAD_IPSUM (ipsum_ready=1): accept p+1 words into ofmap_spad[0..p], then go to ACCUM.
- ACCUM:
  - One MAC per cycle; f innermost, then m, then c. Exactly (q+1)(p+1)(s+1) cycles.
  - ofmap_spad[m] += filter_spad[m][f][c] * ifmap_slot[f][c].
  - Lanes c>q are never used.
- WRITE_OPSUM (opsum_valid=1):
  - Emit ofmap_spad[0..p] in order; cnt advances only on opsum_ready.
  - After word p: if column count == F go to DONE, else SHIFT_IFMAP.
- DONE: done=1, all ready/valid low; return to IDLE when PE_en=0.
- Arithmetic:
  - mode=0: ifmap lane is unsigned, value = lane-128 (MSB inverted, read as signed).
  - mode=1: ifmap lane is signed as-is.
  - Filter lanes are always signed.
  - Product is a 16-bit signed value, sign-extended to PSUM_W. The sum wraps modulo 2^PSUM_W; no saturation.
- Column counter is synchronous on clk, incremented on the final opsum transfer of each column. No derived clocks.
- Valid held high with ready low: state and counters unchanged. opsum is held stable under backpressure.
- Out-of-range config, where s >= MAX_S or p >= MAX_P: behaviour is undefined. The bench does not drive it.
- Reset asserted mid-operation: immediately IDLE, outputs at reset values. The next run needs a full reload.

Decomposition:
- Package pe_pkg:
  - state_t enum: IDLE, LOAD_FILTER, LOAD_IFMAP, SHIFT_IFMAP, LOAD_IPSUM, ACCUM, WRITE_OPSUM, DONE.
  - Config field bit positions and widths.
  - Localparams for index widths ($clog2 of MAX_CH, MAX_S, MAX_P).
- Sub-module pe_mac: combinational mode conversion, signed 8x8 multiply, sign-extend and add to a PSUM_W accumulator input.

Test Plan:
- Minimal signed case: s=0, q=0, p=0, F=0, mode=1; filter 0x00000003, ifmap 0x00000005, ipsum 10 -> one opsum 25 after 1 ACCUM cycle, then done=1.
- Unsigned offset: same dims, mode=0, filter 7, ipsum 4.
  - ifmap 0x00000080 -> opsum 4.
  - Rerun with ifmap 0x00000000 -> opsum 0xFFFFFC84 (-892).
- Full config: s=2, q=3, p=3, F=1; all filter lanes 1, all ifmap lanes 2, mode=1, ipsum 0.
  - Required: 48 ACCUM cycles per column, 4 opsums of 24 per column.
  - One SHIFT word between columns; 8 opsums total, then done.
- Backpressure: hold opsum_ready=0 for 5 cycles during WRITE_OPSUM -> opsum_valid stays 1, opsum value and index are unchanged, no word is skipped or duplicated.
- Reset mid-ACCUM: drop rst_n.
  - All ready/valid, opsum and done go to 0 without waiting for a clk edge.
  - After release, a new minimal run produces the correct result.
- Restart: after done, PE_en=0 for 1 cycle then 1 with a new config -> second run is accepted and produces correct opsums without reset.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and field layout for the parametrised row-stationary PE.
// Index widths are sized for the default scratchpad depths.
package pe_pkg;

   localparam int MAX_CH_DEF = 4;
   localparam int MAX_S_DEF  = 4;
   localparam int MAX_P_DEF  = 4;

   localparam int CH_W = $clog2(MAX_CH_DEF);
   localparam int S_W  = $clog2(MAX_S_DEF);
   localparam int P_W  = $clog2(MAX_P_DEF);

   // i_config layout: {s, mode, p, F, q}
   localparam int CFG_Q_LSB    = 0;
   localparam int CFG_F_LSB    = 2;
   localparam int CFG_F_W      = 5;
   localparam int CFG_P_LSB    = 7;
   localparam int CFG_MODE_BIT = 9;
   localparam int CFG_S_LSB    = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_FILTER,
      LOAD_IFMAP,
      SHIFT_IFMAP,
      LOAD_IPSUM,
      ACCUM,
      WRITE_OPSUM,
      DONE
   } state_t;

endpackage

// File: rtl/pe_mac.sv
// Single-lane MAC: ifmap mode conversion, signed 8x8 multiply, sign-extended accumulate.
// Purely combinational; wraps modulo 2^PSUM_W.
module pe_mac #(
   parameter int IFMAP_W  = 8,
   parameter int FILTER_W = 8,
   parameter int PSUM_W   = 32
) (
   input  logic                mode,
   input  logic [IFMAP_W-1:0]  ifmap_lane,
   input  logic [FILTER_W-1:0] filter_lane,
   input  logic [PSUM_W-1:0]   acc_in,
   output logic [PSUM_W-1:0]   acc_out
);

   localparam int PROD_W = IFMAP_W + FILTER_W;

   logic signed [IFMAP_W-1:0]  act;
   logic signed [FILTER_W-1:0] wgt;
   logic signed [PROD_W-1:0]   prod;

   always_comb begin
      // unsigned mode: flipping the MSB maps x to the signed value x-128
      act     = mode ? ifmap_lane : {~ifmap_lane[IFMAP_W-1], ifmap_lane[IFMAP_W-2:0]};
      wgt     = filter_lane;
      prod    = act * wgt;
      acc_out = acc_in + {{(PSUM_W-PROD_W){prod[PROD_W-1]}}, prod};
   end

endmodule

// File: rtl/pe_param.sv
// Row-stationary PE: loads filters, sliding ifmap window and psums, runs one MAC per
// cycle, then streams p+1 opsums per column; ready/valid decode from state only.
module pe_param
   import pe_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int IFMAP_W     = 8,
   parameter int FILTER_W    = 8,
   parameter int PSUM_W      = 32,
   parameter int MAX_CH      = MAX_CH_DEF,
   parameter int MAX_S       = MAX_S_DEF,
   parameter int MAX_P       = MAX_P_DEF,
   parameter int CONFIG_SIZE = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   PE_en,
   input  logic [CONFIG_SIZE-1:0] i_config,
   input  logic [DATA_BITS-1:0]   ifmap,
   input  logic [DATA_BITS-1:0]   filter,
   input  logic [DATA_BITS-1:0]   ipsum,
   input  logic                   ifmap_valid,
   input  logic                   filter_valid,
   input  logic                   ipsum_valid,
   input  logic                   opsum_ready,
   output logic                   ifmap_ready,
   output logic                   filter_ready,
   output logic                   ipsum_ready,
   output logic [DATA_BITS-1:0]   opsum,
   output logic                   opsum_valid,
   output logic                   done
);

   state_t state, state_n;

   logic [CH_W-1:0]    cfg_q;
   logic [CFG_F_W-1:0] cfg_f;
   logic [P_W-1:0]     cfg_p;
   logic [S_W-1:0]     cfg_s;
   logic               cfg_mode;

   logic [S_W-1:0]     f_idx;
   logic [P_W-1:0]     m_idx;
   logic [CH_W-1:0]    c_idx;
   logic [CFG_F_W-1:0] col;

   logic [DATA_BITS-1:0] filter_spad [MAX_P][MAX_S];
   logic [DATA_BITS-1:0] ifmap_slot  [MAX_S];
   logic [PSUM_W-1:0]    ofmap_spad  [MAX_P];

   logic [IFMAP_W-1:0]  ifmap_lane;
   logic [FILTER_W-1:0] filter_lane;
   logic [PSUM_W-1:0]   mac_out;

   logic f_last, m_last, c_last, col_last;
   logic filter_xfer, ifmap_xfer, ipsum_xfer, opsum_xfer;

   assign filter_ready = (state == LOAD_FILTER);
   assign ifmap_ready  = (state == LOAD_IFMAP) || (state == SHIFT_IFMAP);
   assign ipsum_ready  = (state == LOAD_IPSUM);
   assign opsum_valid  = (state == WRITE_OPSUM);
   assign done         = (state == DONE);
   assign opsum        = opsum_valid ? ofmap_spad[m_idx] : '0;

   assign filter_xfer = filter_valid & filter_ready;
   assign ifmap_xfer  = ifmap_valid & ifmap_ready;
   assign ipsum_xfer  = ipsum_valid & ipsum_ready;
   assign opsum_xfer  = opsum_valid & opsum_ready;

   assign f_last   = (f_idx == cfg_s);
   assign m_last   = (m_idx == cfg_p);
   assign c_last   = (c_idx == cfg_q);
   assign col_last = (col == cfg_f);

   always_comb begin
      ifmap_lane  = '0;
      filter_lane = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (c_idx == CH_W'(i)) begin
            ifmap_lane  = ifmap_slot[f_idx][i*IFMAP_W +: IFMAP_W];
            filter_lane = filter_spad[m_idx][f_idx][i*FILTER_W +: FILTER_W];
         end
      end
   end

   pe_mac #(
      .IFMAP_W  (IFMAP_W),
      .FILTER_W (FILTER_W),
      .PSUM_W   (PSUM_W)
   ) u_mac (
      .mode        (cfg_mode),
      .ifmap_lane  (ifmap_lane),
      .filter_lane (filter_lane),
      .acc_in      (ofmap_spad[m_idx]),
      .acc_out     (mac_out)
   );

   always_comb begin
      state_n = state;
      case (state)
         IDLE:        if (PE_en) state_n = LOAD_FILTER;
         LOAD_FILTER: if (filter_xfer && f_last && m_last) state_n = LOAD_IFMAP;
         LOAD_IFMAP:  if (ifmap_xfer && f_last) state_n = LOAD_IPSUM;
         SHIFT_IFMAP: if (ifmap_xfer) state_n = LOAD_IPSUM;
         LOAD_IPSUM:  if (ipsum_xfer && m_last) state_n = ACCUM;
         ACCUM:       if (f_last && m_last && c_last) state_n = WRITE_OPSUM;
         WRITE_OPSUM: if (opsum_xfer && m_last) state_n = col_last ? DONE : SHIFT_IFMAP;
         DONE:        if (!PE_en) state_n = IDLE;
         default:     state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cfg_q    <= '0;
         cfg_f    <= '0;
         cfg_p    <= '0;
         cfg_s    <= '0;
         cfg_mode <= 1'b0;
         f_idx    <= '0;
         m_idx    <= '0;
         c_idx    <= '0;
         col      <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (PE_en) begin
                  cfg_q    <= i_config[CFG_Q_LSB +: CH_W];
                  cfg_f    <= i_config[CFG_F_LSB +: CFG_F_W];
                  cfg_p    <= i_config[CFG_P_LSB +: P_W];
                  cfg_s    <= i_config[CFG_S_LSB +: S_W];
                  cfg_mode <= i_config[CFG_MODE_BIT];
               end
               f_idx <= '0;
               m_idx <= '0;
               c_idx <= '0;
               col   <= '0;
            end
            LOAD_FILTER: begin
               if (filter_xfer) begin
                  f_idx <= f_last ? '0 : f_idx + 1'b1;
                  if (f_last) m_idx <= m_last ? '0 : m_idx + 1'b1;
               end
            end
            LOAD_IFMAP: begin
               if (ifmap_xfer) f_idx <= f_last ? '0 : f_idx + 1'b1;
            end
            LOAD_IPSUM: begin
               if (ipsum_xfer) m_idx <= m_last ? '0 : m_idx + 1'b1;
            end
            ACCUM: begin
               // f innermost, then m, then channel
               f_idx <= f_last ? '0 : f_idx + 1'b1;
               if (f_last) begin
                  m_idx <= m_last ? '0 : m_idx + 1'b1;
                  if (m_last) c_idx <= c_last ? '0 : c_idx + 1'b1;
               end
            end
            WRITE_OPSUM: begin
               if (opsum_xfer) begin
                  m_idx <= m_last ? '0 : m_idx + 1'b1;
                  if (m_last) col <= col + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Scratchpads carry no reset; every run reloads them before use.
   always_ff @(posedge clk) begin
      case (state)
         LOAD_FILTER: if (filter_xfer) filter_spad[m_idx][f_idx] <= filter;
         LOAD_IFMAP:  if (ifmap_xfer) ifmap_slot[f_idx] <= ifmap;
         SHIFT_IFMAP: begin
            if (ifmap_xfer) begin
               for (int j = 0; j < MAX_S - 1; j++) begin
                  if (j < int'(cfg_s)) ifmap_slot[j] <= ifmap_slot[j+1];
               end
               ifmap_slot[cfg_s] <= ifmap;
            end
         end
         LOAD_IPSUM:  if (ipsum_xfer) ofmap_spad[m_idx] <= ipsum;
         ACCUM:       ofmap_spad[m_idx] <= mac_out;
         default: ;
      endcase
   end

endmodule
